// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four valid/ready requesters.
// The selected word is registered into a single-entry output buffer.

module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    output logic [W-1:0] y_o
);
    always_comb begin
        unique case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end
endmodule

module rr_mux_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid_i,
    input  logic [W-1:0] req_data0_i,
    input  logic [W-1:0] req_data1_i,
    input  logic [W-1:0] req_data2_i,
    input  logic [W-1:0] req_data3_i,
    output logic [3:0]   req_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   out_src_o,
    input  logic         out_ready_i,
    output logic [1:0]   sel_o
);
    // Handshake: a transfer happens on any edge where valid and ready are both high;
    // valid never waits on ready, ready may look at valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [W-1:0] data_q, data_d;
    logic [1:0]   src_q, src_d;

    logic [1:0]   gnt;
    logic         found;
    logic         can_load;
    logic         load;
    logic [W-1:0] mux_data;

    // Search starts one past the last winner and wraps back to it last.
    always_comb begin
        logic [1:0] idx;
        gnt   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_valid_i[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    mux_4_1 #(.W(W)) u_mux (
        .sel_i (gnt),
        .d0_i  (req_data0_i),
        .d1_i  (req_data1_i),
        .d2_i  (req_data2_i),
        .d3_i  (req_data3_i),
        .y_o   (mux_data)
    );

    assign can_load = (state_q == ST_EMPTY) || out_ready_i;
    assign load     = rst_n && can_load && found;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        src_d       = src_q;
        req_ready_o = 4'b0000;
        if (load) begin
            req_ready_o = 4'b0001 << gnt;
            state_d     = ST_FULL;
            ptr_d       = gnt;
            data_d      = mux_data;
            src_d       = gnt;
        end else if (state_q == ST_FULL && out_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 2'd3;
            data_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid_o = (state_q == ST_FULL);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;
    assign sel_o       = gnt;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, streaming, sparse, backpressure,
// idle gap and mid-stream reset, with hand-computed expectations.

module tb_rr_mux_arbiter;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [1:0]   sel;

    int n_checks = 0;
    int n_errors = 0;

    rr_mux_arbiter #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data0_i (d0),
        .req_data1_i (d1),
        .req_data2_i (d2),
        .req_data3_i (d3),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .sel_o       (sel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    logic [W-1:0] exp_d[5] = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    logic [1:0]   exp_s[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] sp_d[3]  = '{4'h7, 4'h3, 4'h7};
    logic [1:0]   sp_s[3]  = '{2'd1, 2'd3, 2'd1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        out_ready = 1'b1;

        // reset values
        #2;
        check_out("rst", 1'b0, 4'h0, 2'd0);
        check("rst.ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        check_out("rst_clk", 1'b0, 4'h0, 2'd0);
        rst_n = 1'b1;
        #1;
        check("rel.ready", 32'(req_ready), 32'b0001);
        check("rel.sel", 32'(sel), 32'd0);

        // round-robin streaming
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, exp_d[i], exp_s[i]);
        end

        // sparse: only 1 and 3
        req_valid = 4'b1010;
        d1 = 4'h7; d3 = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sp%0d.ready02", i), 32'(req_ready & 4'b0101), 32'h0);
            tick();
            check_out($sformatf("sp%0d", i), 1'b1, sp_d[i], sp_s[i]);
        end

        // drain, then load 'hb from requester 1 into the empty buffer
        req_valid = 4'b0000;
        tick();
        check("drain.valid", 32'(out_valid), 32'd0);
        req_valid = 4'b0010;
        d1 = 4'hb;
        out_ready = 1'b0;
        #1;
        check("bp_load.ready", 32'(req_ready), 32'b0010);
        tick();
        check_out("bp_full", 1'b1, 4'hb, 2'd1);

        // backpressure for 3 cycles
        req_valid = 4'hF;
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.ready", i), 32'(req_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 4'hb, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel.ready", 32'(req_ready), 32'b0100);
        tick();
        check_out("bp_rel", 1'b1, 4'hc, 2'd2);

        // idle gap
        req_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("gap%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("gap%0d.ptr", i), 32'(sel), 32'd2);
        end
        req_valid = 4'b0100;
        d2 = 4'hc;
        #1;
        check("gap_req.ready", 32'(req_ready), 32'b0100);
        tick();
        check_out("gap_out", 1'b1, 4'hc, 2'd2);

        // mid-stream reset with 'hd buffered
        req_valid = 4'b1000;
        d3 = 4'hd;
        tick();
        check_out("pre_rst", 1'b1, 4'hd, 2'd3);
        req_valid = 4'b0000;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 4'h0, 2'd0);
        req_valid = 4'hF;
        d0 = 4'h5;
        #1;
        check("mid_rst.ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst.ready", 32'(req_ready), 32'b0001);
        tick();
        check_out("post_rst", 1'b1, 4'h5, 2'd0);
        tick();
        check_out("post_rst2", 1'b1, 4'hb, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
